// File: rtl/remap_acc_if.sv
// rtl/remap_acc_if.sv - remap_acc term-in / sum-out handshake bundle.
// Optional max_o member present when REMAP_ACC_MAX_EN is defined.
`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif

interface remap_acc_if #(
    parameter int NUM_W = `NUM_LENGTH,
    parameter int ACC_W = 40,
    parameter int CNT_W = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [NUM_W-1:0] rslt_i;
    logic             last_i;
    logic             sum_valid_o;
    logic             sum_ready_i;
    logic [ACC_W-1:0] sum_o;
    logic [CNT_W-1:0] cnt_o;
    logic             ovf_o;
`ifdef REMAP_ACC_MAX_EN
    logic [NUM_W-1:0] max_o;
`endif

    modport slave (
        input  in_valid_i, rslt_i, last_i, sum_ready_i,
        output in_ready_o, sum_valid_o, sum_o, cnt_o, ovf_o
`ifdef REMAP_ACC_MAX_EN
        , output max_o
`endif
    );

    modport master (
        output in_valid_i, rslt_i, last_i, sum_ready_i,
        input  in_ready_o, sum_valid_o, sum_o, cnt_o, ovf_o
`ifdef REMAP_ACC_MAX_EN
        , input max_o
`endif
    );
endinterface

// File: rtl/remap_acc.sv
// rtl/remap_acc.sv - saturating burst accumulator after the remap stage.
// REMAP_ACC_MAX_EN adds a per-burst running maximum on max_o.
`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif

module remap_acc #(
    parameter int NUM_W     = `NUM_LENGTH,
    parameter int ACC_W     = 40,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    remap_acc_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
`ifdef REMAP_ACC_MAX_EN
    logic [NUM_W-1:0] max_q, max_d;
`endif

    // One extra bit catches the carry that signals saturation.
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W-1:0] cnt_inc;

    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(bus.rslt_i);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef REMAP_ACC_MAX_EN
        max_d   = max_q;
`endif
        case (state_q)
            IDLE, ACC: begin
                if (bus.in_valid_i) begin
                    acc_d = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                    ovf_d = ovf_q | acc_sum[ACC_W];
                    cnt_d = cnt_inc;
`ifdef REMAP_ACC_MAX_EN
                    if (bus.rslt_i > max_q) max_d = bus.rslt_i;
`endif
                    state_d = (cnt_inc == CNT_W'(BURST_LEN) || bus.last_i) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (bus.sum_ready_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef REMAP_ACC_MAX_EN
                    max_d   = '0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef REMAP_ACC_MAX_EN
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef REMAP_ACC_MAX_EN
            max_q   <= max_d;
`endif
        end
    end

    assign bus.in_ready_o  = (state_q != HOLD);
    assign bus.sum_valid_o = (state_q == HOLD);
    assign bus.sum_o       = acc_q;
    assign bus.cnt_o       = cnt_q;
    assign bus.ovf_o       = ovf_q;
`ifdef REMAP_ACC_MAX_EN
    assign bus.max_o       = max_q;
`endif
endmodule

// File: tb/tb_remap_acc.sv
// tb/tb_remap_acc.sv - directed bench for remap_acc (40-bit and 33-bit instances).
// Extra max_o checks run when REMAP_ACC_MAX_EN is defined.
`timescale 1ns/1ps

module tb_remap_acc;
    localparam int NUM_W = 32;
    localparam int BL    = 4;
    localparam int CW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] rslt = '0;
    logic        last = 1'b0;
    logic        sum_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    remap_acc_if #(.NUM_W(NUM_W), .ACC_W(40), .CNT_W(CW)) bus_a ();
    remap_acc_if #(.NUM_W(NUM_W), .ACC_W(33), .CNT_W(CW)) bus_b ();

    assign bus_a.in_valid_i  = in_valid;
    assign bus_a.rslt_i      = rslt;
    assign bus_a.last_i      = last;
    assign bus_a.sum_ready_i = sum_ready;
    assign bus_b.in_valid_i  = in_valid;
    assign bus_b.rslt_i      = rslt;
    assign bus_b.last_i      = last;
    assign bus_b.sum_ready_i = sum_ready;

    remap_acc #(.NUM_W(NUM_W), .ACC_W(40), .BURST_LEN(BL), .CNT_W(CW)) u_dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    remap_acc #(.NUM_W(NUM_W), .ACC_W(33), .BURST_LEN(BL), .CNT_W(CW)) u_dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the term is accepted.
    task automatic send(input logic [31:0] v, input logic l);
        int n;
        in_valid = 1'b1;
        rslt     = v;
        last     = l;
        n = 0;
        while (!bus_a.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_timeout", 64'(n >= 50), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check_eq("rst_valid", 64'(bus_a.sum_valid_o), 64'd0);
        check_eq("rst_ready", 64'(bus_a.in_ready_o), 64'd1);
        check_eq("rst_sum",   64'(bus_a.sum_o), 64'd0);
        check_eq("rst_cnt",   64'(bus_a.cnt_o), 64'd0);
        check_eq("rst_ovf",   64'(bus_a.ovf_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full burst of four, sink always ready.
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        check_eq("full_valid", 64'(bus_a.sum_valid_o), 64'd1);
        check_eq("full_ready", 64'(bus_a.in_ready_o), 64'd0);
        check_eq("full_sum",   64'(bus_a.sum_o), 64'd10);
        check_eq("full_cnt",   64'(bus_a.cnt_o), 64'd4);
        check_eq("full_ovf",   64'(bus_a.ovf_o), 64'd0);
        @(negedge clk);
        check_eq("full_valid_drop", 64'(bus_a.sum_valid_o), 64'd0);
        check_eq("full_ready_back", 64'(bus_a.in_ready_o), 64'd1);
        check_eq("full_clear_sum",  64'(bus_a.sum_o), 64'd0);

        // Early close via last_i.
        send(32'd5, 1'b0);
        send(32'd7, 1'b1);
        check_eq("early_valid", 64'(bus_a.sum_valid_o), 64'd1);
        check_eq("early_sum",   64'(bus_a.sum_o), 64'd12);
        check_eq("early_cnt",   64'(bus_a.cnt_o), 64'd2);
        check_eq("early_ovf",   64'(bus_a.ovf_o), 64'd0);
        @(negedge clk);

        // Backpressure: sum held while the sink stalls and a term waits.
        sum_ready = 1'b0;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        in_valid = 1'b1;
        rslt     = 32'd9;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ready", 64'(bus_a.in_ready_o), 64'd0);
            check_eq("bp_valid", 64'(bus_a.sum_valid_o), 64'd1);
            check_eq("bp_sum",   64'(bus_a.sum_o), 64'd10);
            @(negedge clk);
        end
        sum_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_idle_ready", 64'(bus_a.in_ready_o), 64'd1);
        check_eq("bp_idle_valid", 64'(bus_a.sum_valid_o), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_next_cnt", 64'(bus_a.cnt_o), 64'd1);
        check_eq("bp_next_sum", 64'(bus_a.sum_o), 64'd9);
        send(32'd1, 1'b1);
        check_eq("bp_next_burst_sum", 64'(bus_a.sum_o), 64'd10);
        check_eq("bp_next_burst_cnt", 64'(bus_a.cnt_o), 64'd2);
        @(negedge clk);

        // Saturation on the 33-bit instance; the 40-bit one does not saturate.
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        check_eq("sat_sum",  64'(bus_b.sum_o), 64'h1_FFFF_FFFF);
        check_eq("sat_cnt",  64'(bus_b.cnt_o), 64'd3);
        check_eq("sat_ovf",  64'(bus_b.ovf_o), 64'd1);
        check_eq("wide_sum", 64'(bus_a.sum_o), 64'h2_FFFF_FFFD);
        check_eq("wide_ovf", 64'(bus_a.ovf_o), 64'd0);
        @(negedge clk);
        send(32'd1, 1'b0);
        send(32'd1, 1'b1);
        check_eq("post_sat_sum", 64'(bus_b.sum_o), 64'd2);
        check_eq("post_sat_ovf", 64'(bus_b.ovf_o), 64'd0);
        @(negedge clk);

        // Asynchronous reset mid-burst discards the partial sum.
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_sum",   64'(bus_a.sum_o), 64'd0);
        check_eq("arst_cnt",   64'(bus_a.cnt_o), 64'd0);
        check_eq("arst_valid", 64'(bus_a.sum_valid_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'd4, 1'b0);
        send(32'd4, 1'b0);
        send(32'd4, 1'b0);
        send(32'd4, 1'b0);
        check_eq("arst_next_sum",   64'(bus_a.sum_o), 64'd16);
        check_eq("arst_next_cnt",   64'(bus_a.cnt_o), 64'd4);
        check_eq("arst_next_valid", 64'(bus_a.sum_valid_o), 64'd1);
        @(negedge clk);

        // Large unsigned term among small ones.
        send(32'd3, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'd9, 1'b0);
        send(32'd1, 1'b0);
        check_eq("max_sum", 64'(bus_a.sum_o), 64'h8000_000D);
`ifdef REMAP_ACC_MAX_EN
        check_eq("max_val", 64'(bus_a.max_o), 64'h8000_0000);
        @(negedge clk);
        check_eq("max_clear", 64'(bus_a.max_o), 64'd0);
`else
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
